serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised bit-serial adder: one full-adder cell iterated LSB-first over WIDTH cycles.
- Successor to the single-bit half/full adder cells.
- Serves area-constrained datapaths that trade latency for gate count.
- Start/busy/done handshake; result registered and held until the next operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..64).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sa_start  input  1  request; sampled only in IDLE.
- sa_A  input  WIDTH  operand A; captured on accepted start.
- sa_B  input  WIDTH  operand B; captured on accepted start.
- sa_cin  input  1  carry-in; captured on accepted start.
- sa_busy  output  1  high while an operation is in progress (RUN or DONE).
- sa_done  output  1  one-cycle pulse; result valid.
- sa_S  output  WIDTH  sum, registered.
- sa_C  output  1  carry-out, registered.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. Assertion forces IDLE immediately and zeroes all state and all outputs: sa_S=0, sa_C=0, sa_busy=0, sa_done=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - sa_start=1 at edge k latches A, B and cin into shift registers a_sh, b_sh and carry register c. Clears counter. Next state RUN.
  - sa_start=0: remain in IDLE.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0], b_sh[0], c).
  - s shifts into MSB of sum_sh; a_sh and b_sh shift right; counter increments.
  - When counter reaches WIDTH-1 at an edge, the next state is DONE.
- Completion edge (k+WIDTH):
  - sa_S <= final sum_sh (including the last bit); sa_C <= final carry.
  - sa_done is high in the cycle following edge k+WIDTH. Latency from start sample to done = WIDTH cycles.
- DONE: lasts exactly one cycle, then IDLE. Earliest next accepted start is the edge ending the DONE cycle+1, i.e. at edge k+WIDTH+1 the FSM is in IDLE and samples start at edge k+WIDTH+2.
- sa_busy = (state != IDLE).
- sa_S and sa_C change only at completion edges. They hold the previous result throughout RUN.
- sa_start during RUN or DONE is ignored; no queueing.
- Operand inputs are don't-care except on the accepted start edge.
- Reset mid-RUN aborts the operation. No done pulse is produced; outputs read 0.
- WIDTH=1: RUN lasts one cycle, giving a registered full adder.
- Arithmetic: {sa_C, sa_S} = A + B + cin, modulo 2^(WIDTH+1). No overflow flag.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sa_sub (1 bit), captured on the accepted start.
  - sa_sub=1: b_sh loads ~sa_B, carry loads 1 (sa_cin ignored), result = A - B.
  - sa_C = 1 means no borrow (A >= B unsigned).
  - sa_sub=0: plain add, identical to the non-macro build.
- Undefined: port sa_sub is absent; add only.

Test Plan:
- WIDTH=8, A=8'h0F, B=8'h01, cin=0, start at edge k -> sa_done high in the cycle after edge k+8, sa_S=8'h10, sa_C=0; sa_busy high for 9 cycles.
- A=8'hFF, B=8'h01, cin=0 -> sa_S=8'h00, sa_C=1. Then A=8'hFF, B=8'hFF, cin=1 -> sa_S=8'hFF, sa_C=1.
- Start pulsed again at edge k+3 with A=8'h55 -> ignored. Result is from the first operands, and sa_S holds the previous value until the completion edge.
- rst_n low mid-RUN at cycle k+4 (asynchronous, between edges) -> outputs immediately 0, no sa_done. After release, a fresh start with 8'h01+8'h02 -> sa_S=8'h03.
- Back-to-back: start held high continuously -> operations complete every WIDTH+2 cycles, each with exactly one sa_done pulse.
- With SERIAL_ADDER_SUB_EN: sa_sub=1, A=8'h05, B=8'h07 -> sa_S=8'hFE, sa_C=0. Then A=8'h07, B=8'h05 -> sa_S=8'h02, sa_C=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell iterated LSB-first over WIDTH cycles, start/busy/done handshake.
// Optional subtract mode (A - B, sa_C = no-borrow) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sa_start,
  input  logic [WIDTH-1:0] sa_A,
  input  logic [WIDTH-1:0] sa_B,
  input  logic             sa_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sa_sub,
`endif
  output logic             sa_busy,
  output logic             sa_done,
  output logic [WIDTH-1:0] sa_S,
  output logic             sa_C
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic             bit_s, bit_c;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = bit_s;
  end

  // Subtraction is A + ~B + 1, so only the B operand and carry-in differ.
  always_comb begin
    b_load = sa_B;
    c_load = sa_cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sa_sub) begin
      b_load = ~sa_B;
      c_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      ST_IDLE: begin
        if (sa_start) begin
          a_d     = sa_A;
          b_d     = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = bit_c;
        sum_d = sum_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = sum_shift;
          co_d    = bit_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign sa_busy = (state_q != ST_IDLE);
  assign sa_done = (state_q == ST_DONE);
  assign sa_S    = s_q;
  assign sa_C    = co_q;

endmodule
